// File: rtl/fpalu_pipe.sv
// fpalu_pipe: 4-stage ADD/SUB/MUL/PASS on left-aligned FP, always normalised, zero/ovf/unf flags.
// Latency 4, 1 op/cycle; every stage holds while out_valid && !out_ready (in_ready mirrors advance).
module fpalu_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 22,
  parameter int MUL_W = 11,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_a_sgn,
  input  logic [EXP_W-1:0] in_a_exp,
  input  logic [MAN_W-1:0] in_a_man,
  input  logic             in_b_sgn,
  input  logic [EXP_W-1:0] in_b_exp,
  input  logic [MAN_W-1:0] in_b_man,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sgn,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam int W    = MAN_W + 2;
  localparam int PW   = 2 * MUL_W;
  localparam int XW   = EXP_W + 2 + $clog2(MAN_W + 3);
  localparam int LZW  = $clog2(W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {OP_PASS = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_MUL = 2'b11} op_e;

  // Mantissas in s1/s2 carry scale 2^MAN_W for add paths; the MUL product sits in l at scale 2^W.
  typedef struct packed {
    logic             sgn;
    logic             sub;
    logic             mul;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [W-1:0]     l;
    logic [MAN_W-1:0] s;
    logic [EXP_W-1:0] sh;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic             sub;
    logic             mul;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [W-1:0]     l;
    logic [MAN_W-1:0] s;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             sgn;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [W-1:0]     v;
    logic [TAG_W-1:0] tag;
  } s3_t;

  logic advance;
  logic s1_vld, s2_vld, s3_vld;
  s1_t  s1_q, s1_n;
  s2_t  s2_q, s2_n;
  s3_t  s3_q, s3_n;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // S1: zero detect, exponent-ordered swap, truncated product
  logic             a_zero, b_zero, b_eff;
  logic             l_sgn, s_sgn;
  logic [EXP_W-1:0] l_exp, s_exp;
  logic [MAN_W-1:0] l_man, s_man;
  logic [PW-1:0]    prod;

  always_comb begin
    a_zero = (in_a_man == '0);
    b_zero = (in_b_man == '0);
    b_eff  = in_b_sgn ^ (in_op == OP_SUB);
    prod   = PW'(in_a_man[MAN_W-1 -: MUL_W]) * PW'(in_b_man[MAN_W-1 -: MUL_W]);
    if (in_b_exp > in_a_exp) begin
      l_sgn = b_eff;    l_exp = in_b_exp; l_man = in_b_man;
      s_sgn = in_a_sgn; s_exp = in_a_exp; s_man = in_a_man;
    end else begin
      l_sgn = in_a_sgn; l_exp = in_a_exp; l_man = in_a_man;
      s_sgn = b_eff;    s_exp = in_b_exp; s_man = in_b_man;
    end
    // A zero L must not let its exponent shift the real operand away
    if (l_man == '0) begin
      l_sgn = s_sgn;
      l_exp = s_exp;
      l_man = s_man;
      s_man = '0;
    end

    s1_n      = '0;
    s1_n.sgn  = in_a_sgn;
    s1_n.zero = a_zero;
    s1_n.exp  = XW'(in_a_exp);
    s1_n.l    = W'(in_a_man);
    s1_n.tag  = in_tag;
    case (in_op)
      OP_ADD, OP_SUB: begin
        s1_n.sgn  = l_sgn;
        s1_n.sub  = l_sgn ^ s_sgn;
        s1_n.zero = (l_man == '0);
        s1_n.exp  = XW'(l_exp);
        s1_n.l    = W'(l_man);
        s1_n.s    = s_man;
        s1_n.sh   = (s_man == '0) ? '0 : (l_exp - s_exp);
      end
      OP_MUL: begin
        s1_n.sgn  = in_a_sgn ^ in_b_sgn;
        s1_n.mul  = 1'b1;
        s1_n.zero = a_zero | b_zero;
        s1_n.exp  = XW'(in_a_exp) + XW'(in_b_exp) - XW'(BIAS);
        s1_n.l    = W'(prod) << (W - PW);
      end
      default: ;
    endcase
  end

  // S2: align the smaller operand
  always_comb begin
    s2_n.sgn  = s1_q.sgn;
    s2_n.sub  = s1_q.sub;
    s2_n.mul  = s1_q.mul;
    s2_n.zero = s1_q.zero;
    s2_n.exp  = s1_q.exp;
    s2_n.l    = s1_q.l;
    s2_n.tag  = s1_q.tag;
    s2_n.s    = (32'(s1_q.sh) >= MAN_W) ? '0 : (s1_q.s >> s1_q.sh);
  end

  // S3: magnitude add/subtract; v is rescaled to 2^W so MUL and ADD share one normaliser
  logic [W-1:0] sum;

  always_comb begin
    sum      = '0;
    s3_n.sgn = s2_q.sgn;
    s3_n.tag = s2_q.tag;
    if (s2_q.mul) begin
      s3_n.v   = s2_q.l;
      s3_n.exp = s2_q.exp;
    end else begin
      if (s2_q.sub) begin
        sum = s2_q.l - W'(s2_q.s);
        if (sum[W-1]) begin
          sum      = -sum;
          s3_n.sgn = ~s2_q.sgn;
        end
      end else begin
        sum = s2_q.l + W'(s2_q.s);
      end
      s3_n.v   = sum << 1;
      s3_n.exp = s2_q.exp + XW'(1);
    end
    s3_n.zero = s2_q.zero | (s3_n.v == '0);
    if (s3_n.zero) s3_n.sgn = 1'b0;
  end

  // S4: leading-zero normalise, then saturate or flush
  logic [LZW-1:0]         lz;
  logic                   found;
  logic signed [XW-1:0]   e4;
  logic [MAN_W-1:0]       m4;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && s3_q.v[i]) begin
        lz    = LZW'(W - 1 - i);
        found = 1'b1;
      end
    end
    e4 = $signed(s3_q.exp) - $signed(XW'(lz));
    m4 = MAN_W'((s3_q.v << lz) >> (W - MAN_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s3_vld    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_valid <= 1'b0;
      out_sgn   <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
      out_tag   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (advance) begin
      s1_vld    <= in_valid;
      s2_vld    <= s1_vld;
      s3_vld    <= s2_vld;
      out_valid <= s3_vld;
      s1_q      <= s1_n;
      s2_q      <= s2_n;
      s3_q      <= s3_n;
      out_tag   <= s3_q.tag;
      if (s3_q.zero) begin
        out_sgn  <= 1'b0;
        out_exp  <= '0;
        out_man  <= '0;
        out_zero <= 1'b1;
        out_ovf  <= 1'b0;
        out_unf  <= 1'b0;
      end else if (e4 < 0) begin
        out_sgn  <= 1'b0;
        out_exp  <= '0;
        out_man  <= '0;
        out_zero <= 1'b0;
        out_ovf  <= 1'b0;
        out_unf  <= 1'b1;
      end else if (e4 > EMAX) begin
        out_sgn  <= s3_q.sgn;
        out_exp  <= '1;
        out_man  <= '1;
        out_zero <= 1'b0;
        out_ovf  <= 1'b1;
        out_unf  <= 1'b0;
      end else begin
        out_sgn  <= s3_q.sgn;
        out_exp  <= e4[EXP_W-1:0];
        out_man  <= m4;
        out_zero <= 1'b0;
        out_ovf  <= 1'b0;
        out_unf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpalu_pipe.sv
// Directed vectors for fpalu_pipe plus streaming-backpressure and mid-stream reset sequences.
module tb_fpalu_pipe;
  localparam int EXP_W = 6;
  localparam int MAN_W = 22;
  localparam int MUL_W = 11;
  localparam int TAG_W = 5;
  localparam logic [1:0] PASS = 2'd0, ADD = 2'd1, SUB = 2'd2, MUL = 2'd3;
  localparam int NV = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_op = '0;
  logic in_a_sgn = 1'b0, in_b_sgn = 1'b0;
  logic [EXP_W-1:0] in_a_exp = '0, in_b_exp = '0;
  logic [MAN_W-1:0] in_a_man = '0, in_b_man = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic out_valid, out_ready = 1'b1;
  logic out_sgn, out_zero, out_ovf, out_unf;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic [TAG_W-1:0] out_tag;

  fpalu_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .MUL_W(MUL_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a_sgn(in_a_sgn), .in_a_exp(in_a_exp), .in_a_man(in_a_man),
    .in_b_sgn(in_b_sgn), .in_b_exp(in_b_exp), .in_b_man(in_b_man),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sgn(out_sgn), .out_exp(out_exp), .out_man(out_man), .out_tag(out_tag),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic        as;
    logic [5:0]  ae;
    logic [21:0] am;
    logic        bs;
    logic [5:0]  be;
    logic [21:0] bm;
    logic        es;
    logic [5:0]  ee;
    logic [21:0] em;
    logic        ez, eo, eu;
  } vec_t;

  vec_t vt [NV];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [1:0] op,
                              input logic as, input logic [5:0] ae, input logic [21:0] am,
                              input logic bs, input logic [5:0] be, input logic [21:0] bm,
                              input logic es, input logic [5:0] ee, input logic [21:0] em,
                              input logic ez, input logic eo, input logic eu);
    vec_t v;
    v = {op, as, ae, am, bs, be, bm, es, ee, em, ez, eo, eu};
    return v;
  endfunction

  function automatic logic [63:0] pk(input logic s, input logic [5:0] e, input logic [21:0] m,
                                     input logic z, input logic o, input logic u, input logic [4:0] t);
    return {27'b0, s, e, m, z, o, u, t};
  endfunction

  function automatic logic [63:0] cur_res();
    return {27'b0, out_sgn, out_exp, out_man, out_zero, out_ovf, out_unf, out_tag};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic do_op(input vec_t v, input logic [4:0] tag, input string name);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = v.op; in_tag = tag;
    in_a_sgn = v.as; in_a_exp = v.ae; in_a_man = v.am;
    in_b_sgn = v.bs; in_b_exp = v.be; in_b_man = v.bm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'd4);
    check(name, cur_res(), pk(v.es, v.ee, v.em, v.ez, v.eo, v.eu, tag));
  endtask

  initial begin
    int k, rcv, cyc, cnt;
    logic stalled;
    logic [63:0] snap;

    vt[0]  = mk(ADD,  0, 32, 22'h200000, 0, 32, 22'h200000, 0, 33, 22'h200000, 0, 0, 0);
    vt[1]  = mk(MUL,  0, 32, 22'h200000, 0, 32, 22'h200000, 0, 32, 22'h200000, 0, 0, 0);
    vt[2]  = mk(MUL,  0, 63, 22'h200000, 0, 63, 22'h200000, 0, 63, 22'h3FFFFF, 0, 1, 0);
    vt[3]  = mk(MUL,  0,  1, 22'h200000, 0,  1, 22'h200000, 0,  0, 22'h000000, 0, 0, 1);
    vt[4]  = mk(SUB,  0, 32, 22'h200000, 0, 32, 22'h200000, 0,  0, 22'h000000, 1, 0, 0);
    vt[5]  = mk(SUB,  0, 32, 22'h200000, 0, 33, 22'h200000, 1, 32, 22'h200000, 0, 0, 0);
    vt[6]  = mk(ADD,  0, 50, 22'h000000, 0, 32, 22'h200000, 0, 32, 22'h200000, 0, 0, 0);
    vt[7]  = mk(PASS, 1, 40, 22'h100000, 0,  0, 22'h000000, 1, 39, 22'h200000, 0, 0, 0);
    vt[8]  = mk(PASS, 1, 20, 22'h000000, 0,  5, 22'h123456, 0,  0, 22'h000000, 1, 0, 0);
    vt[9]  = mk(ADD,  0, 32, 22'h300000, 0, 31, 22'h300000, 0, 33, 22'h240000, 0, 0, 0);
    vt[10] = mk(ADD,  0, 32, 22'h200000, 1, 32, 22'h300000, 1, 31, 22'h200000, 0, 0, 0);
    vt[11] = mk(ADD,  0, 60, 22'h200000, 0, 20, 22'h3FFFFF, 0, 60, 22'h200000, 0, 0, 0);
    vt[12] = mk(ADD,  0, 63, 22'h300000, 0, 63, 22'h300000, 0, 63, 22'h3FFFFF, 0, 1, 0);
    vt[13] = mk(ADD,  1, 63, 22'h300000, 1, 63, 22'h300000, 1, 63, 22'h3FFFFF, 0, 1, 0);
    vt[14] = mk(MUL,  0, 16, 22'h200000, 0, 16, 22'h200000, 0,  0, 22'h200000, 0, 0, 0);
    vt[15] = mk(MUL,  0, 16, 22'h200000, 0, 15, 22'h200000, 0,  0, 22'h000000, 0, 0, 1);
    vt[16] = mk(MUL,  1, 32, 22'h3FFFFF, 0, 32, 22'h200000, 1, 32, 22'h3FF800, 0, 0, 0);
    vt[17] = mk(MUL,  1, 32, 22'h200000, 0, 40, 22'h000000, 0,  0, 22'h000000, 1, 0, 0);
    vt[18] = mk(SUB,  1, 32, 22'h200000, 1, 34, 22'h200000, 0, 33, 22'h300000, 0, 0, 0);
    vt[19] = mk(ADD,  0, 40, 22'h280000, 1, 45, 22'h000000, 0, 40, 22'h280000, 0, 0, 0);

    // Reset state
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_outs", cur_res(), 64'd0);
    #12 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) begin
      do_op(vt[i], 5'(i), $sformatf("vec%0d", i));
    end

    // Streaming with out_ready pattern 1,0,0,1,0,0...
    k = 0; rcv = 0; cyc = 0; stalled = 1'b0; snap = '0;
    while (rcv < 8 && cyc < 200) begin
      @(posedge clk); #1;
      if (stalled) check("stall_hold", {cur_res()[62:0], out_valid}, snap);
      out_ready = (cyc % 3 == 0);
      in_valid  = (k < 8);
      in_op     = (k % 2 == 1) ? MUL : PASS;
      in_a_sgn  = 1'b0; in_a_exp = 6'(10 + k); in_a_man = 22'h200000;
      in_b_sgn  = 1'b0; in_b_exp = 6'd32;      in_b_man = 22'h200000;
      in_tag    = 5'(k);
      #1;
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d", rcv), cur_res(), pk(0, 6'(10 + rcv), 22'h200000, 0, 0, 0, 5'(rcv)));
        rcv++;
      end
      stalled = out_valid && !out_ready;
      snap = {cur_res()[62:0], out_valid};
      if (in_valid && in_ready) k++;
      cyc++;
    end
    check("stream_count", 64'(rcv), 64'd8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("stream_no_dup", 64'(cnt), 64'd0);

    // Reset with ops in flight
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_op = PASS; in_tag = 5'(20 + j);
      in_a_sgn = 1'b0; in_a_exp = 6'(20 + j); in_a_man = 22'h200000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_outs", cur_res(), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("no_stale", 64'(cnt), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    do_op(vt[0], 5'd9, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
